// File: rtl/eco32_core_fpu_seq.sv
// Sequencer for the shared iterative div/sqrt unit: one pending request per thread, round-robin grant,
// held write-back port, per-thread kill. Optional watchdog abort with ECO32_FPU_SEQ_WDOG_EN.
module eco32_core_fpu_seq #(
  parameter int WDOG_CYC = 64,
  parameter int WDOG_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_stb,
  input  logic        req_tid,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_ry_addr,
  input  logic [1:0]  req_ry_tag,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  req_rdy,
  output logic        req_drop,
  input  logic [1:0]  kill,
  output logic        u_start,
  output logic [1:0]  u_op,
  output logic [31:0] u_a,
  output logic [31:0] u_b,
  input  logic        u_done,
  input  logic [31:0] u_res,
  output logic        wb_stb,
  output logic        wb_tid,
  output logic [4:0]  wb_addr,
  output logic [1:0]  wb_tag,
  output logic [31:0] wb_data,
  output logic        wb_err,
  input  logic        wb_ack
);

`ifdef ECO32_FPU_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;
  state_t state, state_nx;

  logic [1:0]       slot_vld;
  logic [1:0][1:0]  slot_op, slot_tag;
  logic [1:0][4:0]  slot_addr;
  logic [1:0][31:0] slot_a, slot_b;

  logic [1:0]       acc, cand;
  logic [1:0][1:0]  eff_op, eff_tag;
  logic [1:0][4:0]  eff_addr;
  logic [1:0][31:0] eff_a, eff_b;

  logic             last_grant, cur_tid, aborted, drain, kill_cur;
  logic [4:0]       cur_addr;
  logic [1:0]       cur_tag;
  logic [WDOG_W-1:0] wdog_cnt;
  logic             wdog_hit;
  logic             grant, gnt_tid, wb_load, wb_release, wdog_exp;

  assign req_rdy  = ~slot_vld;
  assign kill_cur = kill[cur_tid];
  assign wdog_hit = WDOG_EN && (state == WAIT) && (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

  // A request arriving while idle is granted straight from the port so u_start follows next cycle.
  always_comb begin
    acc = '0;
    for (int t = 0; t < 2; t++) begin
      acc[t]      = req_stb && (req_tid == 1'(t)) && !slot_vld[t] && !kill[t];
      eff_op[t]   = acc[t] ? req_op      : slot_op[t];
      eff_tag[t]  = acc[t] ? req_ry_tag  : slot_tag[t];
      eff_addr[t] = acc[t] ? req_ry_addr : slot_addr[t];
      eff_a[t]    = acc[t] ? req_a       : slot_a[t];
      eff_b[t]    = acc[t] ? req_b       : slot_b[t];
    end
    cand = (slot_vld | acc) & ~kill;
  end

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    gnt_tid    = 1'b0;
    wb_load    = 1'b0;
    wb_release = 1'b0;
    wdog_exp   = 1'b0;
    case (state)
      IDLE: if (!drain && |cand) begin
        grant    = 1'b1;
        gnt_tid  = (&cand) ? ~last_grant : cand[1];
        state_nx = START;
      end
      START: state_nx = WAIT;
      WAIT: if (u_done || wdog_hit) begin
        wdog_exp = !u_done;
        if (aborted || kill_cur) state_nx = IDLE;
        else begin
          wb_load  = 1'b1;
          state_nx = WB;
        end
      end
      WB: if (wb_ack || kill_cur) begin
        wb_release = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld   <= '0;
      slot_op    <= '0;
      slot_tag   <= '0;
      slot_addr  <= '0;
      slot_a     <= '0;
      slot_b     <= '0;
      req_drop   <= 1'b0;
      u_start    <= 1'b0;
      u_op       <= '0;
      u_a        <= '0;
      u_b        <= '0;
      cur_tid    <= 1'b0;
      cur_addr   <= '0;
      cur_tag    <= '0;
      aborted    <= 1'b0;
      drain      <= 1'b0;
      last_grant <= 1'b1;
      wdog_cnt   <= '0;
      wb_stb     <= 1'b0;
      wb_tid     <= 1'b0;
      wb_addr    <= '0;
      wb_tag     <= '0;
      wb_data    <= '0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (kill[t]) slot_vld[t] <= 1'b0;
        else if (acc[t]) begin
          slot_vld[t]  <= 1'b1;
          slot_op[t]   <= req_op;
          slot_tag[t]  <= req_ry_tag;
          slot_addr[t] <= req_ry_addr;
          slot_a[t]    <= req_a;
          slot_b[t]    <= req_b;
        end else if (wb_release && cur_tid == 1'(t)) slot_vld[t] <= 1'b0;
      end
      req_drop <= req_stb && !(|acc);
      u_start  <= grant;
      if (grant) begin
        u_op     <= eff_op[gnt_tid];
        u_a      <= eff_a[gnt_tid];
        u_b      <= eff_b[gnt_tid];
        cur_tid  <= gnt_tid;
        cur_addr <= eff_addr[gnt_tid];
        cur_tag  <= eff_tag[gnt_tid];
      end
      // Killed in flight: slot is freed now, the unit's late result is dropped when it lands.
      if (grant) aborted <= 1'b0;
      else if ((state == START || state == WAIT) && kill_cur) aborted <= 1'b1;
      // After a watchdog abort the unit still owes one u_done; hold off new grants until it drains.
      if (wdog_exp) drain <= 1'b1;
      else if (u_done) drain <= 1'b0;
      if (WDOG_EN && state == WAIT && !u_done) wdog_cnt <= wdog_cnt + 1'b1;
      else wdog_cnt <= '0;
      if (wb_load) begin
        wb_stb  <= 1'b1;
        wb_tid  <= cur_tid;
        wb_addr <= cur_addr;
        wb_tag  <= cur_tag;
        wb_data <= u_done ? u_res : QNAN;
      end else if (wb_release) wb_stb <= 1'b0;
      if (state == WB && state_nx == IDLE) last_grant <= cur_tid;
    end
  end

`ifdef ECO32_FPU_SEQ_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wb_err <= 1'b0;
    else if (wb_load) wb_err <= wdog_exp;
  end
`else
  assign wb_err = 1'b0;
`endif

endmodule
